// File: rtl/csum_seq.sv
// csum_seq: control sequencer for an external byte-serial 16-bit ones'-complement
// checksum engine. It initialises the engine with the pseudo-header partial sum and
// streams the payload bytes into it. It then pads an odd length and folds any pending
// end-around carry. Finally it latches the complemented checksum and pulses done.
// Build option: define CSUM_ZERO_SUB_EN to report 16'hFFFF instead of a computed
// checksum of 16'h0000 (UDP zero substitution).
module csum_seq #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      init_sum,
    input  logic [LEN_W-1:0] len,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      csum,
    output logic             ck_init,
    output logic [15:0]      ck_initsum,
    output logic             ck_en,
    output logic [7:0]       ck_d,
    input  logic [15:0]      ck_sum,
    input  logic             ck_c
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PAD    = 3'd3;
    localparam logic [2:0] S_FOLD   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [15:0]      init_q;
    logic             odd_q;
    logic [LEN_W-1:0] cnt;
    logic             hs;

    // Final checksum from the folded engine sum, with optional zero substitution.
    function automatic logic [15:0] final_csum(input logic [15:0] sum);
        logic [15:0] c;
        c = ~sum;
`ifdef CSUM_ZERO_SUB_EN
        if (c == 16'h0000) c = 16'hFFFF;
`endif
        return c;
    endfunction

    // A payload byte is consumed only while streaming.
    assign hs = s_valid && (state == S_DATA);

    // Next-state selection; the last byte handshake decides between padding and folding.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = (cnt != '0) ? S_DATA : S_FOLD;
            S_DATA:   if (hs && (cnt == LEN_W'(1))) state_nxt = odd_q ? S_PAD : S_FOLD;
            S_PAD:    state_nxt = S_FOLD;
            S_FOLD:   if (!ck_c) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Engine controls and handshake outputs decoded purely from the current state.
    always_comb begin
        s_ready    = 1'b0;
        ck_init    = 1'b0;
        ck_initsum = 16'h0000;
        ck_en      = 1'b0;
        ck_d       = 8'h00;
        busy       = (state != S_IDLE);
        done       = (state == S_FINISH);
        case (state)
            S_LOAD: begin
                ck_init    = 1'b1;
                ck_initsum = init_q;
            end
            S_DATA: begin
                s_ready = 1'b1;
                ck_en   = s_valid;
                ck_d    = s_data;
            end
            S_PAD:  ck_en = 1'b1;
            S_FOLD: ck_en = ck_c;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Remaining-byte counter: loaded on an accepted start, decremented per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_IDLE && start) begin
            cnt <= len;
        end else if (hs) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    // Capture the request parameters; they are only observed after LOAD, so no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            init_q <= init_sum;
            odd_q  <= len[0];
        end
    end

    // Result register: updated only when folding has settled, i.e. on entry to FINISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum <= 16'h0000;
        else if (state == S_FOLD && !ck_c) csum <= final_csum(ck_sum);
    end

`ifndef SYNTHESIS
    logic [1:0] fold_cnt;

    // Count fold adds in the current FOLD visit, saturating at three.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fold_cnt <= 2'd0;
        end else if (state == S_FOLD) begin
            if (ck_c && fold_cnt != 2'd3) fold_cnt <= fold_cnt + 2'd1;
        end else begin
            fold_cnt <= 2'd0;
        end
    end

    // Folding must settle within three end-around adds; a fourth means the engine misbehaves.
    fold_limit: assert property (@(posedge clk) disable iff (rst)
        !(state == S_FOLD && ck_c && fold_cnt == 2'd3));
`endif

endmodule

// File: tb/tb_csum_seq.sv
// Testbench for csum_seq: drives directed transactions, emulates the external engine,
// and checks every cycle against a transaction-level reference plus literal vectors.
module tb_csum_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] init_sum;
    logic [15:0] len;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic [15:0] csum;
    logic        ck_init;
    logic [15:0] ck_initsum;
    logic        ck_en;
    logic [7:0]  ck_d;
    logic [15:0] ck_sum;
    logic        ck_c;

    csum_seq #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .init_sum(init_sum), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .busy(busy),
        .done(done), .csum(csum), .ck_init(ck_init), .ck_initsum(ck_initsum),
        .ck_en(ck_en), .ck_d(ck_d), .ck_sum(ck_sum), .ck_c(ck_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External engine emulation: alternating low/high byte adds with carry chaining.
    logic [15:0] e_sum = 16'h0000;
    logic        e_c   = 1'b0;
    logic        e_ph  = 1'b0;
    always @(posedge clk) begin
        if (ck_init) begin
            e_sum <= ck_initsum;
            e_c   <= 1'b0;
            e_ph  <= 1'b0;
        end else if (ck_en) begin
            if (!e_ph) {e_c, e_sum[7:0]}  <= {1'b0, e_sum[7:0]}  + {1'b0, ck_d} + {8'h00, e_c};
            else       {e_c, e_sum[15:8]} <= {1'b0, e_sum[15:8]} + {1'b0, ck_d} + {8'h00, e_c};
            e_ph <= ~e_ph;
        end
    end
    assign ck_sum = e_sum;
    assign ck_c   = e_c;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Payload of the transaction being driven.
    logic [7:0] tx_bytes [0:15];

    // Reference checksum: ones'-complement sum of the init value and little-endian words.
    function automatic logic [15:0] ref_csum(input logic [15:0] ini, input int n);
        int unsigned acc;
        logic [15:0] r;
        acc = {16'h0000, ini};
        for (int i = 0; i < n; i += 2) begin
            acc += {24'h0, tx_bytes[i]};
            if (i + 1 < n) acc += {16'h0, tx_bytes[i+1], 8'h00};
        end
        while (acc > 32'h0000FFFF) acc = (acc & 32'h0000FFFF) + (acc >> 16);
        r = ~acc[15:0];
`ifdef CSUM_ZERO_SUB_EN
        if (r == 16'h0000) r = 16'hFFFF;
`endif
        return r;
    endfunction

    // Transaction tracking for the per-cycle checker and the literal checks.
    bit          active = 0;
    int          t0, rem, tail_from, fin, folds, hs_cnt;
    bit          odd;
    logic [15:0] m_init, exp_csum;
    logic [15:0] held = 16'h0000;
    int          done_cnt = 0;
    int          r_rel, r_folds, r_hs;
    logic [15:0] r_csum, r_sum;

    // Per-cycle checker, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_busy", busy, 0);       chk("rst_s_ready", s_ready, 0);
            chk("rst_done", done, 0);       chk("rst_ck_init", ck_init, 0);
            chk("rst_ck_en", ck_en, 0);     chk("rst_ck_initsum", ck_initsum, 0);
            chk("rst_ck_d", ck_d, 0);       chk("rst_csum", csum, 0);
            active = 0;
            held   = 16'h0000;
        end else if (!active) begin
            chk("idle_busy", busy, 0);      chk("idle_s_ready", s_ready, 0);
            chk("idle_done", done, 0);      chk("idle_ck_init", ck_init, 0);
            chk("idle_ck_en", ck_en, 0);    chk("idle_ck_initsum", ck_initsum, 0);
            chk("idle_ck_d", ck_d, 0);      chk("idle_csum_held", csum, held);
            if (start) begin
                active    = 1;
                t0        = cyc;
                rem       = int'(len);
                odd       = len[0];
                m_init    = init_sum;
                exp_csum  = ref_csum(init_sum, int'(len));
                tail_from = (len == 0) ? cyc + 2 : -1;
                fin       = -1;
                folds     = 0;
                hs_cnt    = 0;
            end
        end else if (cyc == t0 + 1) begin
            chk("load_busy", busy, 1);      chk("load_ck_init", ck_init, 1);
            chk("load_initsum", ck_initsum, m_init);
            chk("load_s_ready", s_ready, 0); chk("load_ck_en", ck_en, 0);
            chk("load_done", done, 0);      chk("load_csum_held", csum, held);
        end else if (rem > 0) begin
            chk("data_busy", busy, 1);      chk("data_s_ready", s_ready, 1);
            chk("data_ck_init", ck_init, 0); chk("data_ck_en", ck_en, s_valid);
            chk("data_ck_d", ck_d, s_data); chk("data_done", done, 0);
            chk("data_csum_held", csum, held);
            if (s_valid) begin
                rem--;
                hs_cnt++;
                if (rem == 0) tail_from = cyc + (odd ? 2 : 1);
            end
        end else if (cyc < tail_from) begin
            chk("pad_s_ready", s_ready, 0); chk("pad_ck_en", ck_en, 1);
            chk("pad_ck_d", ck_d, 0);       chk("pad_done", done, 0);
            chk("pad_busy", busy, 1);
        end else if (fin < 0) begin
            chk("fold_s_ready", s_ready, 0); chk("fold_done", done, 0);
            chk("fold_busy", busy, 1);      chk("fold_ck_d", ck_d, 0);
            chk("fold_ck_init", ck_init, 0); chk("fold_csum_held", csum, held);
            if (ck_c) begin
                chk("fold_ck_en", ck_en, 1);
                folds++;
            end else begin
                chk("fold_ck_en", ck_en, 0);
                fin = cyc + 1;
            end
        end else begin
            chk("fin_done", done, 1);       chk("fin_csum", csum, exp_csum);
            chk("fin_busy", busy, 1);       chk("fin_ck_en", ck_en, 0);
            chk("fin_s_ready", s_ready, 0); chk("fin_fold_bound", folds <= 3, 1);
            r_rel   = cyc - t0;
            r_csum  = csum;
            r_folds = folds;
            r_hs    = hs_cnt;
            r_sum   = ck_sum;
            held    = exp_csum;
            active  = 0;
            done_cnt++;
        end
    end

    // Runs one transaction; entered and left just after a rising edge. abort_after>0
    // asserts rst right after that many byte handshakes instead of waiting for done.
    task automatic run_txn(input logic [15:0] ini, input int n, input int gap,
                           input bit mid_start, input int abort_after);
        int  idx = 0;
        int  g = 0;
        int  guard = 0;
        bit  hs;
        bit  ms_done = 0;
        int  d0;
        d0       = done_cnt;
        start    = 1'b1;
        init_sum = ini;
        len      = 16'(n);
        s_valid  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < n && guard < 500) begin
            s_valid = (g == 0);
            s_data  = tx_bytes[idx];
            if (mid_start && idx == 2 && !ms_done) begin
                start   = 1'b1;
                ms_done = 1;
            end
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
            if (hs) begin
                idx++;
                g = gap;
                if (abort_after == idx) begin
                    rst     = 1'b1;
                    s_valid = 1'b0;
                    @(posedge clk);
                    @(posedge clk); #1;
                    rst = 1'b0;
                    return;
                end
            end else if (g > 0) begin
                g--;
            end
        end
        if (idx < n) chk("feed_timeout", idx, n);
        // Keep offering junk so any consumption past len would show up.
        s_valid = 1'b1;
        s_data  = 8'hEE;
        guard   = 0;
        while (done_cnt == d0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        #1;
        s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; init_sum = 16'h0; len = 16'h0;
        s_valid = 1'b0; s_data = 8'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Two bytes, s_valid held high.
        tx_bytes[0] = 8'h34; tx_bytes[1] = 8'h12;
        run_txn(16'h0000, 2, 0, 0, 0);
        chk("t1_csum", r_csum, 16'hEDCB); chk("t1_rel", r_rel, 5);
        chk("t1_folds", r_folds, 0);      chk("t1_sum", r_sum, 16'h1234);

        // Odd length, back-to-back with the previous run.
        tx_bytes[0] = 8'hAB;
        run_txn(16'h0000, 1, 0, 0, 0);
        chk("t2_csum", r_csum, 16'hFF54); chk("t2_rel", r_rel, 5);
        chk("t2_sum", r_sum, 16'h00AB);

        // One fold add.
        tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h00;
        run_txn(16'hFFFF, 2, 0, 0, 0);
        chk("t3_csum", r_csum, 16'hFFFE); chk("t3_rel", r_rel, 6);
        chk("t3_folds", r_folds, 1);      chk("t3_sum", r_sum, 16'h0001);

        // Zero length.
        run_txn(16'hFFFF, 0, 0, 0, 0);
`ifdef CSUM_ZERO_SUB_EN
        chk("t4_csum", r_csum, 16'hFFFF);
`else
        chk("t4_csum", r_csum, 16'h0000);
`endif
        chk("t4_rel", r_rel, 3);          chk("t4_hs", r_hs, 0);

        // Gapped stream with a start pulse during DATA.
        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33; tx_bytes[3] = 8'h44;
        run_txn(16'h0000, 4, 3, 1, 0);
        chk("t5_csum", r_csum, 16'h99BB); chk("t5_hs", r_hs, 4);
        chk("t5_sum", r_sum, 16'h6644);

        // Computed-zero result after a carry fold.
        tx_bytes[0] = 8'hFF; tx_bytes[1] = 8'hFF;
        run_txn(16'hFFFF, 2, 0, 0, 0);
`ifdef CSUM_ZERO_SUB_EN
        chk("t7_csum", r_csum, 16'hFFFF);
`else
        chk("t7_csum", r_csum, 16'h0000);
`endif
        chk("t7_folds", r_folds, 1);      chk("t7_rel", r_rel, 6);

        // Reset mid-packet, then a clean run.
        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33; tx_bytes[3] = 8'h44;
        run_txn(16'h0000, 4, 0, 0, 2);
        chk("t6_csum_cleared", csum, 16'h0000);
        chk("t6_busy_cleared", busy, 0);
        tx_bytes[0] = 8'h34; tx_bytes[1] = 8'h12;
        run_txn(16'h0000, 2, 0, 0, 0);
        chk("t6_csum", r_csum, 16'hEDCB); chk("t6_rel", r_rel, 5);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
